// File: rtl/instr_fifo.sv
// ---------------------------------------------------------------------------
// instr_fifo
//   Micro-instruction queue between the decode stage (producer) and the
//   issue/dispatch stage (consumer). Depth is 2^AW entries of DW bits each.
//   The head entry is presented on data_pop combinationally, so the consumer
//   sees it with zero read latency. A word written at one edge is visible at
//   the head after that edge. There is no write-to-read bypass.
//
// Parameters
//   DW     micro-instruction width in bits
//   AW     address width; depth = 2^AW
//
// Ports
//   CLK        in   single clock, rising edge
//   RSTn       in   asynchronous active-low reset; clears pointers and storage
//   flush      in   synchronous discard of all entries, beats push/pop
//   push       in   write request from decode
//   data_push  in   micro-instruction to store
//   full       out  no free entry, push is not accepted
//   pop        in   read request from issue/dispatch
//   data_pop   out  oldest stored entry (head)
//   empty      out  no valid entry, data_pop is meaningless
// ---------------------------------------------------------------------------
module instr_fifo #(
  parameter int DW = 150,
  parameter int AW = 2
) (
  input  logic          CLK,
  input  logic          RSTn,
  input  logic          flush,
  input  logic          push,
  input  logic [DW-1:0] data_push,
  output logic          full,
  input  logic          pop,
  output logic [DW-1:0] data_pop,
  output logic          empty
);

  localparam int DEPTH = 1 << AW;

  // Pointers carry one extra wrap bit so that full and empty can be told
  // apart when the index bits match.
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [DW-1:0] mem [DEPTH];

  logic          push_acc;
  logic          pop_acc;

  // Status comes only from registered pointers, so full/empty never depend
  // combinationally on push or pop.
  assign empty = (rd_ptr == wr_ptr);
  assign full  = (rd_ptr[AW] != wr_ptr[AW]) &&
                 (rd_ptr[AW-1:0] == wr_ptr[AW-1:0]);

  // When full with push and pop together, full blocks the push while the pop
  // is taken. When empty, empty blocks the pop even if a push arrives, which
  // is what prevents any bypass path.
  assign push_acc = push && !full  && !flush;
  assign pop_acc  = pop  && !empty && !flush;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_acc) wr_ptr <= wr_ptr + 1'b1;
      if (pop_acc)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage is cleared on reset so the head reads as zero until written.
  // Flush leaves the contents alone, since only the pointers define validity.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_acc) begin
      mem[wr_ptr[AW-1:0]] <= data_push;
    end
  end

  assign data_pop = mem[rd_ptr[AW-1:0]];

endmodule

// File: tb/tb_instr_fifo.sv
module tb_instr_fifo;

  localparam int DW = 150;
  localparam int AW = 2;

  logic          CLK;
  logic          RSTn;
  logic          flush;
  logic          push;
  logic [DW-1:0] data_push;
  logic          full;
  logic          pop;
  logic [DW-1:0] data_pop;
  logic          empty;

  int total;
  int bad;

  instr_fifo #(.DW(DW), .AW(AW)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .flush     (flush),
    .push      (push),
    .data_push (data_push),
    .full      (full),
    .pop       (pop),
    .data_pop  (data_pop),
    .empty     (empty)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    RSTn = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; data_push = '0;
    #2;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_empty got=%0b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%0b exp=0", full); end
    total++; if (data_pop !== '0) begin bad++; $display("FAIL rst_data got=%0h exp=0", data_pop); end
    push = 1'b1; pop = 1'b1; data_push = 'h55;
    tick;
    tick;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL rst_push_ignored empty got=%0b exp=1", empty); end
    total++; if (data_pop !== '0) begin bad++; $display("FAIL rst_push_ignored data got=%0h exp=0", data_pop); end
    push = 1'b0; pop = 1'b0; data_push = '0;
    RSTn = 1'b1;
    tick;
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL post_rst empty=%0b full=%0b exp 1/0", empty, full); end
  endtask

  task automatic test_single_push;
    push = 1'b1; data_push = 'h1;
    tick;
    push = 1'b0;
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL single_empty got=%0b exp=0", empty); end
    total++; if (data_pop !== DW'('h1)) begin bad++; $display("FAIL single_data got=%0h exp=1", data_pop); end
    pop = 1'b1;
    tick;
    pop = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL single_pop_empty got=%0b exp=1", empty); end
  endtask

  task automatic test_fill_overflow;
    logic [DW-1:0] vals [4];
    vals[0] = 'hA; vals[1] = 'hB; vals[2] = 'hC; vals[3] = 'hD;
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; data_push = vals[i];
      tick;
      if (i == 2) begin
        total++; if (full !== 1'b0) begin bad++; $display("FAIL fill_full_3 got=%0b exp=0", full); end
      end
    end
    total++; if (full !== 1'b1) begin bad++; $display("FAIL fill_full_4 got=%0b exp=1", full); end
    data_push = 'hE;
    tick;
    push = 1'b0;
    total++; if (full !== 1'b1) begin bad++; $display("FAIL overflow_full got=%0b exp=1", full); end
    for (int i = 0; i < 4; i++) begin
      total++; if (data_pop !== vals[i]) begin bad++; $display("FAIL fill_pop%0d got=%0h exp=%0h", i, data_pop, vals[i]); end
      pop = 1'b1;
      tick;
      pop = 1'b0;
    end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL fill_drained empty=%0b full=%0b exp 1/0", empty, full); end
  endtask

  task automatic test_simul_boundaries;
    logic [DW-1:0] vals [4];
    vals[0] = 'hA; vals[1] = 'hB; vals[2] = 'hC; vals[3] = 'hD;
    for (int i = 0; i < 4; i++) begin
      push = 1'b1; data_push = vals[i];
      tick;
    end
    // full: push 0xF together with pop
    data_push = 'hF; push = 1'b1; pop = 1'b1;
    total++; if (data_pop !== DW'('hA)) begin bad++; $display("FAIL full_pp_head got=%0h exp=a", data_pop); end
    tick;
    push = 1'b0; pop = 1'b0;
    total++; if (full !== 1'b0) begin bad++; $display("FAIL full_pp_full got=%0b exp=0", full); end
    total++; if (data_pop !== DW'('hB)) begin bad++; $display("FAIL full_pp_next got=%0h exp=b", data_pop); end
    for (int i = 1; i < 4; i++) begin
      total++; if (data_pop !== vals[i]) begin bad++; $display("FAIL full_pp_drain%0d got=%0h exp=%0h", i, data_pop, vals[i]); end
      pop = 1'b1;
      tick;
      pop = 1'b0;
    end
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL full_pp_f_dropped empty got=%0b exp=1", empty); end
    // empty: push 0x5 together with pop, no bypass
    data_push = 'h5; push = 1'b1; pop = 1'b1;
    tick;
    push = 1'b0; pop = 1'b0;
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL empty_pp_empty got=%0b exp=0", empty); end
    total++; if (data_pop !== DW'('h5)) begin bad++; $display("FAIL empty_pp_data got=%0h exp=5", data_pop); end
    pop = 1'b1;
    tick;
    pop = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL empty_pp_drain got=%0b exp=1", empty); end
  endtask

  task automatic test_wrap;
    logic [DW-1:0] exp_v;
    push = 1'b1; data_push = 'h99;
    tick;
    exp_v = 'h99;
    for (int i = 1; i <= 10; i++) begin
      push = 1'b1; pop = 1'b1; data_push = DW'(i);
      total++; if (data_pop !== exp_v) begin bad++; $display("FAIL wrap_pop%0d got=%0h exp=%0h", i, data_pop, exp_v); end
      tick;
      total++; if (empty === 1'b1 || full === 1'b1) begin bad++; $display("FAIL wrap_status%0d empty=%0b full=%0b exp 0/0", i, empty, full); end
      exp_v = DW'(i);
    end
    push = 1'b0; pop = 1'b0;
    total++; if (data_pop !== DW'(10)) begin bad++; $display("FAIL wrap_last got=%0h exp=a", data_pop); end
    pop = 1'b1;
    tick;
    pop = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_drain got=%0b exp=1", empty); end
  endtask

  task automatic test_flush;
    for (int i = 1; i <= 3; i++) begin
      push = 1'b1; data_push = DW'('h20 + i);
      tick;
    end
    flush = 1'b1; push = 1'b1; pop = 1'b1; data_push = 'h66;
    tick;
    flush = 1'b0; push = 1'b0; pop = 1'b0;
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL flush_status empty=%0b full=%0b exp 1/0", empty, full); end
    push = 1'b1; data_push = 'h7;
    tick;
    push = 1'b0;
    total++; if (data_pop !== DW'('h7) || empty !== 1'b0) begin bad++; $display("FAIL flush_repush data=%0h empty=%0b exp 7/0", data_pop, empty); end
  endtask

  task automatic test_async_reset;
    push = 1'b1; data_push = 'h8;
    tick;
    push = 1'b0;
    @(posedge CLK);
    #3;
    RSTn = 1'b0;
    #1;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL async_empty got=%0b exp=1", empty); end
    total++; if (data_pop !== '0) begin bad++; $display("FAIL async_data got=%0h exp=0", data_pop); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL async_full got=%0b exp=0", full); end
    push = 1'b1; data_push = 'h3C;
    tick;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL async_hold_empty got=%0b exp=1", empty); end
    RSTn = 1'b1;
    tick;
    push = 1'b0;
    total++; if (data_pop !== DW'('h3C) || empty !== 1'b0) begin bad++; $display("FAIL async_repush data=%0h empty=%0b exp 3c/0", data_pop, empty); end
    pop = 1'b1;
    tick;
    pop = 1'b0;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL async_drain got=%0b exp=1", empty); end
  endtask

  initial begin
    total = 0;
    bad = 0;
    test_reset;
    test_single_push;
    test_fill_overflow;
    test_simul_boundaries;
    test_wrap;
    test_flush;
    test_async_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
